// File: rtl/decrypt_ctrl.sv
// Streaming dot-product decryptor: result = sum(key[i] * ct[i]) truncated to PLAINTEXT_WIDTH.
// One element per cycle; out_valid the cycle after the last beat; ct_ready low while a result waits.
module decrypt_ctrl #(
  parameter int PLAINTEXT_WIDTH  = 6,
  parameter int DIMENSION        = 1,
  parameter int CIPHERTEXT_WIDTH = 10,
  localparam int ACC_W = 2 * CIPHERTEXT_WIDTH + 1,
  localparam int IDX_W = (DIMENSION + 1 > 1) ? $clog2(DIMENSION + 1) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        key_wr_en,
  input  logic [IDX_W-1:0]            key_wr_idx,
  input  logic [CIPHERTEXT_WIDTH-1:0] key_wr_data,
  input  logic                        ct_valid,
  input  logic [CIPHERTEXT_WIDTH-1:0] ct_data,
  output logic                        ct_ready,
  input  logic                        abort,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PLAINTEXT_WIDTH-1:0]  result,
  output logic                        busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIMENSION);

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [IDX_W-1:0]            r_idx;
  logic [ACC_W-1:0]            r_acc;
  logic [CIPHERTEXT_WIDTH-1:0] r_key [DIMENSION+1];

  logic                        w_ct_ready;
  logic                        w_ct_fire;
  logic                        w_key_we;
  logic [CIPHERTEXT_WIDTH-1:0] w_key_sel;
  logic [ACC_W-1:0]            w_key_ext;
  logic [ACC_W-1:0]            w_ct_ext;
  logic [ACC_W-1:0]            w_prod;

  // Key select by the running element index; out-of-range indices read as zero.
  always_comb begin
    w_key_sel = '0;
    for (int k = 0; k <= DIMENSION; k++) begin
      if (r_idx == IDX_W'(k)) begin
        w_key_sel = r_key[k];
      end
    end
  end

  // Key is unsigned and ct signed; both widened to ACC_W so the low ACC_W bits
  // of the unsigned multiply equal the signed product.
  assign w_key_ext = {{(ACC_W - CIPHERTEXT_WIDTH){1'b0}}, w_key_sel};
  assign w_ct_ext  = {{(ACC_W - CIPHERTEXT_WIDTH){ct_data[CIPHERTEXT_WIDTH-1]}}, ct_data};
  assign w_prod    = w_key_ext * w_ct_ext;

  assign w_ct_ready = ((r_state == S_IDLE) || (r_state == S_ACCUM)) && !abort;
  assign w_ct_fire  = w_ct_ready && ct_valid;
  assign w_key_we   = key_wr_en && (r_state == S_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (ct_valid) begin
            w_state_nxt = (DIMENSION == 0) ? S_DONE : S_ACCUM;
          end
        end
        S_ACCUM: begin
          if (ct_valid && (r_idx == LAST_IDX)) begin
            w_state_nxt = S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            w_state_nxt = S_IDLE;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Abort clears the index but leaves acc alone; the next first beat reloads it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      r_acc <= '0;
    end else if (abort) begin
      r_idx <= '0;
    end else if (w_ct_fire) begin
      if (r_state == S_IDLE) begin
        r_acc <= w_prod;
        r_idx <= (DIMENSION == 0) ? '0 : IDX_W'(1);
      end else begin
        r_acc <= r_acc + w_prod;
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= DIMENSION; k++) begin
        r_key[k] <= '0;
      end
    end else if (w_key_we) begin
      for (int k = 0; k <= DIMENSION; k++) begin
        if (key_wr_idx == IDX_W'(k)) begin
          r_key[k] <= key_wr_data;
        end
      end
    end
  end

  assign ct_ready  = w_ct_ready;
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state == S_ACCUM) || (r_state == S_DONE);
  assign result    = r_acc[PLAINTEXT_WIDTH-1:0];

endmodule

// File: tb/tb_decrypt_ctrl.sv
// Bench for decrypt_ctrl (DIMENSION=1): directed table, corner sequences, randomized vectors vs dot-product model.
module tb_decrypt_ctrl;

  localparam int PW = 6;
  localparam int CW = 10;

  logic          clk;
  logic          rst_n;
  logic          key_wr_en;
  logic [0:0]    key_wr_idx;
  logic [CW-1:0] key_wr_data;
  logic          ct_valid;
  logic [CW-1:0] ct_data;
  logic          ct_ready;
  logic          abort;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] result;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int tb_key [2];

  decrypt_ctrl #(
    .PLAINTEXT_WIDTH (PW),
    .DIMENSION       (1),
    .CIPHERTEXT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_wr_en  (key_wr_en),
    .key_wr_idx (key_wr_idx),
    .key_wr_data(key_wr_data),
    .ct_valid   (ct_valid),
    .ct_data    (ct_data),
    .ct_ready   (ct_ready),
    .abort      (abort),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .result     (result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Plaintext = dot product of the modelled key store with the ciphertext, mod 2^PW.
  function automatic int model(input int c0, input int c1);
    return (tb_key[0] * c0 + tb_key[1] * c1) & ((1 << PW) - 1);
  endfunction

  // Tasks enter and leave just after a falling edge.
  task automatic set_key(input int idx, input int val);
    key_wr_en   = 1'b1;
    key_wr_idx  = 1'(idx);
    key_wr_data = CW'(val);
    @(posedge clk); @(negedge clk);
    key_wr_en = 1'b0;
    tb_key[idx] = val;
  endtask

  task automatic run_vec(input int c0, input int c1, input int gap, input int stall,
                         input int exp, input string nm);
    ct_valid = 1'b1;
    ct_data  = CW'(c0);
    #1 chk({nm, "_rdy_beat0"}, int'(ct_ready), 1);
    @(posedge clk); @(negedge clk);
    ct_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); @(negedge clk);
      chk({nm, "_gap_busy"}, int'(busy), 1);
      chk({nm, "_gap_vld"}, int'(out_valid), 0);
    end
    ct_valid = 1'b1;
    ct_data  = CW'(c1);
    #1 chk({nm, "_rdy_beat1"}, int'(ct_ready), 1);
    chk({nm, "_vld_early"}, int'(out_valid), 0);
    @(posedge clk); @(negedge clk);
    ct_valid = 1'b0;
    chk({nm, "_vld"}, int'(out_valid), 1);
    chk({nm, "_result"}, int'(result), exp);
    chk({nm, "_rdy_done"}, int'(ct_ready), 0);
    for (int s = 0; s < stall; s++) begin
      out_ready = 1'b0;
      @(posedge clk); @(negedge clk);
      chk({nm, "_stall_vld"}, int'(out_valid), 1);
      chk({nm, "_stall_res"}, int'(result), exp);
      chk({nm, "_stall_rdy"}, int'(ct_ready), 0);
      chk({nm, "_stall_busy"}, int'(busy), 1);
    end
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    out_ready = 1'b0;
    chk({nm, "_post_vld"}, int'(out_valid), 0);
    chk({nm, "_post_busy"}, int'(busy), 0);
    chk({nm, "_post_rdy"}, int'(ct_ready), 1);
  endtask

  typedef struct {
    int    k0;
    int    k1;
    int    c0;
    int    c1;
    int    stall;
    int    exp;
    string nm;
  } vec_t;

  initial begin
    vec_t tbl [5];
    tbl[0] = '{3,    5,    7,    -2,   0, 11, "basic"};
    tbl[1] = '{1,    2,    -1,   -3,   0, 57, "negacc"};
    tbl[2] = '{3,    5,    7,    -2,   3, 11, "stall3"};
    tbl[3] = '{1023, 1023, -512, -512, 0, 0,  "maxneg"};
    tbl[4] = '{1023, 1023, 511,  511,  1, 2,  "maxpos"};

    rst_n = 1'b0; key_wr_en = 1'b0; key_wr_idx = '0; key_wr_data = '0;
    ct_valid = 1'b0; ct_data = '0; abort = 1'b0; out_ready = 1'b0;
    tb_key[0] = 0; tb_key[1] = 0;
    #1;
    chk("rst_vld", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(result), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rst_rdy", int'(ct_ready), 1);

    foreach (tbl[i]) begin
      set_key(0, tbl[i].k0);
      set_key(1, tbl[i].k1);
      run_vec(tbl[i].c0, tbl[i].c1, 0, tbl[i].stall, tbl[i].exp, tbl[i].nm);
    end

    // Key writes during ACCUM and DONE are dropped.
    set_key(0, 3);
    set_key(1, 5);
    ct_valid = 1'b1; ct_data = CW'(7);
    @(posedge clk); @(negedge clk);
    ct_data = CW'(-2);
    key_wr_en = 1'b1; key_wr_idx = 1'b1; key_wr_data = CW'(9);
    @(posedge clk); @(negedge clk);
    ct_valid = 1'b0;
    chk("kacc_vld", int'(out_valid), 1);
    chk("kacc_result", int'(result), 11);
    key_wr_idx = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    key_wr_en = 1'b0; out_ready = 1'b0;
    run_vec(7, -2, 0, 0, 11, "key_kept");
    set_key(1, 9);
    run_vec(7, -2, 0, 0, 3, "key_idle");
    set_key(1, 5);

    // Abort with a beat presented in ACCUM.
    ct_valid = 1'b1; ct_data = CW'(7);
    @(posedge clk); @(negedge clk);
    ct_data = CW'(-2); abort = 1'b1;
    #1 chk("abort_rdy", int'(ct_ready), 0);
    @(posedge clk); @(negedge clk);
    abort = 1'b0; ct_valid = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_vld", int'(out_valid), 0);
    chk("abort_rdy_after", int'(ct_ready), 1);
    run_vec(7, -2, 0, 0, 11, "post_abort");

    // Abort beats a simultaneous output handshake in DONE.
    ct_valid = 1'b1; ct_data = CW'(1);
    @(posedge clk); @(negedge clk);
    ct_data = CW'(1);
    @(posedge clk); @(negedge clk);
    ct_valid = 1'b0;
    chk("dabort_vld_pre", int'(out_valid), 1);
    chk("dabort_res_pre", int'(result), 8);
    abort = 1'b1; out_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0; out_ready = 1'b0;
    chk("dabort_vld", int'(out_valid), 0);
    chk("dabort_busy", int'(busy), 0);
    run_vec(-5, 4, 1, 0, model(-5, 4), "post_dabort");

    // Reset mid-vector clears keys and partial sum.
    ct_valid = 1'b1; ct_data = CW'(7);
    @(posedge clk); @(negedge clk);
    chk("mid_busy", int'(busy), 1);
    ct_valid = 1'b0; rst_n = 1'b0;
    #1;
    chk("mrst_vld", int'(out_valid), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_result", int'(result), 0);
    @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    tb_key[0] = 0; tb_key[1] = 0;
    #1 chk("mrst_rdy", int'(ct_ready), 1);
    run_vec(7, -2, 0, 0, 0, "zero_keys");
    run_vec(300, -137, 0, 0, 0, "zero_keys2");

    for (int n = 0; n < 40; n++) begin
      int c0;
      int c1;
      set_key(0, int'($urandom_range(0, 1023)));
      set_key(1, int'($urandom_range(0, 1023)));
      c0 = int'($urandom_range(0, 1023)) - 512;
      c1 = int'($urandom_range(0, 1023)) - 512;
      run_vec(c0, c1, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
              model(c0, c1), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
